// File: rtl/display_pkg.sv
// Shared types and display-code constants for the seven-segment scan controller.
package display_pkg;
    typedef logic [6:0] dcode_t;

    localparam dcode_t DC_BLANK = 7'h40;
    localparam dcode_t DC_DP    = 7'h20;
    localparam dcode_t DC_DASH  = 7'h10;
endpackage

// File: rtl/sevenseg_ext_n.sv
// Combinational decoder from a 7-bit display code to active-low segments g..a and dp.
module sevenseg_ext_n
    import display_pkg::*;
(
    input  dcode_t     code,
    output logic [6:0] segs_n,
    output logic       dp_n
);

    always_comb begin
        segs_n = 7'h7F;
        dp_n   = 1'b1;
        if (!code[6]) begin
            if (code[5]) begin
                dp_n = 1'b0;
            end else if (code[4]) begin
                segs_n = 7'b0111111;
            end else begin
                // Codes D and E have no glyph and stay dark.
                case (code[3:0])
                    4'h0:    segs_n = 7'b1000000;
                    4'h1:    segs_n = 7'b1111001;
                    4'h2:    segs_n = 7'b0100100;
                    4'h3:    segs_n = 7'b0110000;
                    4'h4:    segs_n = 7'b0011001;
                    4'h5:    segs_n = 7'b0010010;
                    4'h6:    segs_n = 7'b0000010;
                    4'h7:    segs_n = 7'b1111000;
                    4'h8:    segs_n = 7'b0000000;
                    4'h9:    segs_n = 7'b0010000;
                    4'hA:    segs_n = 7'b0001000;
                    4'hB:    segs_n = 7'b0000011;
                    4'hC:    segs_n = 7'b1000110;
                    4'hF:    segs_n = 7'b0001110;
                    default: segs_n = 7'h7F;
                endcase
            end
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed scan controller with shadow/active banks and tear-free frame commits.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero codes of the active bank.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int NDIGITS = 8,
    parameter int DIV     = 100_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [$clog2(NDIGITS)-1:0] wr_addr,
    input  logic [6:0]                 wr_data,
    input  logic                       commit,
    output logic                       commit_pend,
    output logic                       frame_done,
    output logic [NDIGITS-1:0]         an_n,
    output logic [6:0]                 segs_n,
    output logic                       dp_n
);

    localparam int AW = $clog2(NDIGITS);
    localparam int PW = $clog2(DIV);

    logic [PW-1:0]        presc_reg;
    logic [AW-1:0]        idx_reg;
    logic                 commit_pend_reg;
    logic [NDIGITS-1:0]   an_n_reg;
    logic [6:0]           segs_n_reg;
    logic                 dp_n_reg;
    dcode_t               shadow_reg [NDIGITS];
    dcode_t               active_reg [NDIGITS];

    logic                 tick;
    logic                 boundary;
    logic                 copy;
    logic [NDIGITS-1:0]   wr_hit;
    dcode_t               disp_code;
    logic [6:0]           dec_segs_n;
    logic                 dec_dp_n;

    assign tick     = (presc_reg == PW'(DIV - 1));
    assign boundary = tick && (idx_reg == AW'(NDIGITS - 1));
    assign copy     = boundary && (commit_pend_reg || commit);

    genvar gi;
    generate
        for (gi = 0; gi < NDIGITS; gi++) begin : g_hit
            // Out-of-range addresses match no digit and are dropped.
            assign wr_hit[gi] = wr_en && (int'(wr_addr) == gi);
        end
    endgenerate

`ifdef LEADING_ZERO_BLANK_EN
    logic [NDIGITS-1:0] lz_blank;
    logic               lz_run;

    always_comb begin
        lz_blank = '0;
        lz_run   = 1'b1;
        for (int d = NDIGITS - 1; d >= 0; d--) begin
            lz_run      = lz_run && (active_reg[d] == 7'd0);
            lz_blank[d] = lz_run && (d != 0);
        end
    end

    assign disp_code = lz_blank[idx_reg] ? DC_BLANK : active_reg[idx_reg];
`else
    assign disp_code = active_reg[idx_reg];
`endif

    sevenseg_ext_n u_dec (
        .code   (disp_code),
        .segs_n (dec_segs_n),
        .dp_n   (dec_dp_n)
    );

    // Copy reads the pre-edge shadow, so a write in the boundary cycle lands only in shadow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < NDIGITS; d++) begin
                shadow_reg[d] <= DC_BLANK;
                active_reg[d] <= DC_BLANK;
            end
        end else begin
            for (int d = 0; d < NDIGITS; d++) begin
                if (copy) begin
                    active_reg[d] <= shadow_reg[d];
                end
                if (wr_hit[d]) begin
                    shadow_reg[d] <= wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_reg       <= '0;
            idx_reg         <= '0;
            commit_pend_reg <= 1'b0;
            an_n_reg        <= '1;
            segs_n_reg      <= 7'h7F;
            dp_n_reg        <= 1'b1;
        end else begin
            presc_reg <= tick ? '0 : presc_reg + PW'(1);
            if (tick) begin
                idx_reg <= (idx_reg == AW'(NDIGITS - 1)) ? '0 : idx_reg + AW'(1);
            end

            if (copy) begin
                commit_pend_reg <= 1'b0;
            end else if (commit) begin
                commit_pend_reg <= 1'b1;
            end

            // First cycle of each slot is dark to avoid ghosting onto the next digit.
            if (tick) begin
                an_n_reg   <= '1;
                segs_n_reg <= 7'h7F;
                dp_n_reg   <= 1'b1;
            end else begin
                an_n_reg   <= ~(NDIGITS'(1) << idx_reg);
                segs_n_reg <= dec_segs_n;
                dp_n_reg   <= dec_dp_n;
            end
        end
    end

    assign frame_done  = boundary;
    assign commit_pend = commit_pend_reg;
    assign an_n        = an_n_reg;
    assign segs_n      = segs_n_reg;
    assign dp_n        = dp_n_reg;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl (NDIGITS=4, DIV=4) against a cycle-count model.
module tb_display_scan_ctrl;

    localparam int N   = 4;
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = 2'd0;
    logic [6:0] wr_data = 7'd0;
    logic       commit = 1'b0;
    logic       commit_pend;
    logic       frame_done;
    logic [3:0] an_n;
    logic [6:0] segs_n;
    logic       dp_n;

    int checks = 0;
    int failures = 0;

    logic [6:0] m_shadow [N];
    logic [6:0] m_active [N];
    logic       m_pend;
    int         m_cnt;

    display_scan_ctrl #(.NDIGITS(N), .DIV(DIV)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .commit      (commit),
        .commit_pend (commit_pend),
        .frame_done  (frame_done),
        .an_n        (an_n),
        .segs_n      (segs_n),
        .dp_n        (dp_n)
    );

    always #5 clk = ~clk;

    // Returns {dp_n, segs_n} for a display code.
    function automatic logic [7:0] ref_glyph(input logic [6:0] c);
        if (c[6]) return {1'b1, 7'h7F};
        if (c[5]) return {1'b0, 7'h7F};
        if (c[4]) return {1'b1, 7'b0111111};
        case (c[3:0])
            4'h0: return {1'b1, 7'b1000000};
            4'h1: return {1'b1, 7'b1111001};
            4'h2: return {1'b1, 7'b0100100};
            4'h3: return {1'b1, 7'b0110000};
            4'h4: return {1'b1, 7'b0011001};
            4'h5: return {1'b1, 7'b0010010};
            4'h6: return {1'b1, 7'b0000010};
            4'h7: return {1'b1, 7'b1111000};
            4'h8: return {1'b1, 7'b0000000};
            4'h9: return {1'b1, 7'b0010000};
            4'hA: return {1'b1, 7'b0001000};
            4'hB: return {1'b1, 7'b0000011};
            4'hC: return {1'b1, 7'b1000110};
            4'hF: return {1'b1, 7'b0001110};
            default: return {1'b1, 7'h7F};
        endcase
    endfunction

    function automatic logic suppressed(input int d);
`ifdef LEADING_ZERO_BLANK_EN
        if (d == 0) return 1'b0;
        for (int j = d; j < N; j++) begin
            if (m_active[j] != 7'd0) return 1'b0;
        end
        return 1'b1;
`else
        return (d < 0);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < N; d++) begin
            m_shadow[d] = 7'h40;
            m_active[d] = 7'h40;
        end
        m_pend = 1'b0;
        m_cnt  = 0;
    endtask

    task automatic model_edge(input logic we, input logic [1:0] a, input logic [6:0] dat,
                              input logic cm);
        bit bnd;
        bnd = (m_cnt % DIV == DIV - 1) && ((m_cnt / DIV) % N == N - 1);
        if (bnd && (m_pend || cm)) begin
            for (int d = 0; d < N; d++) m_active[d] = m_shadow[d];
            m_pend = 1'b0;
        end else if (cm) begin
            m_pend = 1'b1;
        end
        if (we && int'(a) < N) m_shadow[a] = dat;
        m_cnt++;
    endtask

    task automatic check_outputs();
        int p;
        int i;
        logic [7:0] g;
        logic [3:0] ea;
        logic [6:0] code;
        p = m_cnt % DIV;
        i = (m_cnt / DIV) % N;
        if (p == 0) begin
            ea = 4'hF;
            g  = {1'b1, 7'h7F};
        end else begin
            ea   = ~(4'b0001 << i);
            code = suppressed(i) ? 7'h40 : m_active[i];
            g    = ref_glyph(code);
        end
        chk("an_n", 32'(an_n), 32'(ea));
        chk("segs_n", 32'(segs_n), 32'(g[6:0]));
        chk("dp_n", 32'(dp_n), 32'(g[7]));
        chk("frame_done", 32'(frame_done), 32'((p == DIV - 1) && (i == N - 1)));
        chk("commit_pend", 32'(commit_pend), 32'(m_pend));
    endtask

    task automatic step(input logic we, input logic [1:0] a, input logic [6:0] dat,
                        input logic cm);
        wr_en   = we;
        wr_addr = a;
        wr_data = dat;
        commit  = cm;
        @(posedge clk);
        model_edge(we, a, dat, cm);
        #1;
        check_outputs();
        wr_en  = 1'b0;
        commit = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 2'd0, 7'd0, 1'b0);
    endtask

    task automatic wait_fd();
        bit found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (frame_done === 1'b1) found = 1;
            else idle(1);
        end
        chk("wait_frame_done", 32'(found), 32'd1);
    endtask

    task automatic wait_an(input logic [3:0] t);
        bit found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (an_n === t) found = 1;
            else idle(1);
        end
        chk("wait_an", 32'(found), 32'd1);
    endtask

    initial begin
        int first_fd;
        model_reset();

        // Reset held: outputs at reset values.
        #12;
        chk("rst_an_n", 32'(an_n), 32'hF);
        chk("rst_segs_n", 32'(segs_n), 32'h7F);
        chk("rst_dp_n", 32'(dp_n), 32'd1);
        chk("rst_pend", 32'(commit_pend), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        rst = 1'b0;
        check_outputs();

        // All digits blank after release.
        idle(20);

        // Load 3,2,1,0 into addr 0..3 and commit.
        step(1'b1, 2'd0, 7'd3, 1'b0);
        step(1'b1, 2'd1, 7'd2, 1'b0);
        step(1'b1, 2'd2, 7'd1, 1'b0);
        step(1'b1, 2'd3, 7'd0, 1'b0);
        step(1'b0, 2'd0, 7'd0, 1'b1);
        chk("pend_after_commit", 32'(commit_pend), 32'd1);
        wait_fd();
        chk("pend_at_boundary", 32'(commit_pend), 32'd1);
        idle(1);
        chk("pend_cleared", 32'(commit_pend), 32'd0);
        wait_an(4'b0111);
`ifdef LEADING_ZERO_BLANK_EN
        chk("digit3_zero", 32'(segs_n), 32'h7F);
`else
        chk("digit3_zero", 32'(segs_n), 32'(7'b1000000));
`endif
        wait_an(4'b1011);
        chk("digit2_one", 32'(segs_n), 32'(7'b1111001));

        // Shadow-only write stays invisible until committed.
        step(1'b1, 2'd1, 7'h20, 1'b0);
        idle(3 * N * DIV);
        wait_an(4'b1101);
        chk("digit1_unchanged", 32'(segs_n), 32'(7'b0100100));
        step(1'b0, 2'd0, 7'd0, 1'b1);
        wait_fd();
        idle(1);
        wait_an(4'b1101);
        chk("digit1_dp_segs", 32'(segs_n), 32'h7F);
        chk("digit1_dp_on", 32'(dp_n), 32'd0);

        // Commit and write together in the boundary cycle.
        wait_fd();
        step(1'b1, 2'd0, 7'd8, 1'b1);
        chk("pend_boundary_commit", 32'(commit_pend), 32'd0);
        wait_an(4'b1110);
        chk("digit0_kept", 32'(segs_n), 32'(7'b0110000));
        step(1'b0, 2'd0, 7'd0, 1'b1);
        wait_fd();
        idle(1);
        wait_an(4'b1110);
        chk("digit0_eight", 32'(segs_n), 32'(7'b0000000));

        // One full frame: anode walk and frame_done period.
        wait_fd();
        first_fd = 0;
        for (int k = 1; k <= N * DIV; k++) begin
            int p;
            int s;
            idle(1);
            p = (k - 1) % DIV;
            s = (k - 1) / DIV;
            chk("an_walk", 32'(an_n), (p == 0) ? 32'hF : 32'(4'(~(4'b0001 << s))));
            if (frame_done === 1'b1 && first_fd == 0) first_fd = k;
        end
        chk("frame_period", 32'(first_fd), 32'(N * DIV));

        // Reset mid-frame drops a pending commit and all bank contents.
        step(1'b1, 2'd2, 7'd9, 1'b0);
        step(1'b0, 2'd0, 7'd0, 1'b1);
        idle(2);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_an_n", 32'(an_n), 32'hF);
        chk("midrst_segs_n", 32'(segs_n), 32'h7F);
        chk("midrst_dp_n", 32'(dp_n), 32'd1);
        chk("midrst_pend", 32'(commit_pend), 32'd0);
        chk("midrst_frame_done", 32'(frame_done), 32'd0);
        #2;
        rst = 1'b0;
        model_reset();
        check_outputs();
        idle(2 * N * DIV);

`ifdef LEADING_ZERO_BLANK_EN
        step(1'b1, 2'd3, 7'd0, 1'b0);
        step(1'b1, 2'd2, 7'd0, 1'b0);
        step(1'b1, 2'd1, 7'd5, 1'b0);
        step(1'b1, 2'd0, 7'd0, 1'b1);
        wait_fd();
        idle(1);
        wait_an(4'b1110);
        chk("lz_digit0", 32'(segs_n), 32'(7'b1000000));
        wait_an(4'b1101);
        chk("lz_digit1", 32'(segs_n), 32'(7'b0010010));
        wait_an(4'b1011);
        chk("lz_digit2", 32'(segs_n), 32'h7F);
        wait_an(4'b0111);
        chk("lz_digit3", 32'(segs_n), 32'h7F);
`endif

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            logic       we;
            logic       cm;
            logic [1:0] a;
            logic [6:0] dat;
            we  = ($urandom_range(0, 1) == 1);
            cm  = ($urandom_range(0, 7) == 0);
            a   = 2'($urandom_range(0, N - 1));
            dat = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom);
            step(we, a, dat, cm);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
